fp_regfile_mp: RTL and testbench

Parametrised multi-port floating-point register file. It succeeds the single-write, three-read FP register file with:

- a configurable number of read and write ports, for dual-retire and D-extension configurations;
- an optional hardwired-zero register;
- optional write-to-read bypass;
- a post-reset hardware clear sweep, since distributed RAM has no reset.

It sits in WB next to the integer register file. Read addresses come from PD early source fields. Write ports are driven by the WB/FPU retire paths.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/sdp_dist_ram.sv | 24 ++
 rtl/fp_regfile_mp.sv | 138 +++++++++++++
 tb/tb_fp_regfile_mp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: FP register file port-count defaults and sweep FSM states.
package riscv_pkg;

  localparam int FP_RF_NUM_READ  = 3;
  localparam int FP_RF_NUM_WRITE = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fp_rf_state_e;

endpackage

// File: rtl/sdp_dist_ram.sv
// Simple dual-port distributed RAM: one synchronous write port, one asynchronous read port.
module sdp_dist_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto LUT RAM; its owner clears it by sweeping.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file: LVT-selected banks of distributed RAM, optional bypass and
// zero register, with a post-reset sweep that zeroes the port-0 banks.
module fp_regfile_mp
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = FP_RF_NUM_READ,
  parameter int NUM_WRITE  = FP_RF_NUM_WRITE,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_stall,
  input  logic [NUM_WRITE-1:0]                 i_we,
  input  logic [NUM_WRITE-1:0][AW-1:0]         i_waddr,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] i_wdata,
  input  logic [NUM_READ-1:0][AW-1:0]          i_raddr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  o_rdata,
  output logic                                 o_init_done,
  output logic                                 o_wr_collision
);

  localparam int LW = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;

  fp_rf_state_e                         state;
  logic [AW-1:0]                        clr_cnt;
  logic                                 running;
  logic [NUM_WRITE-1:0]                 we_eff;
  logic                                 collision;
  logic [NUM_WRITE-1:0]                 wr_en;
  logic [NUM_WRITE-1:0][AW-1:0]         wr_addr;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0]                bank_rdata [NUM_WRITE][NUM_READ];
  logic [LW-1:0]                        rd_sel [NUM_READ];

  assign running     = (state == RUN);
  assign o_init_done = running;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    collision = 1'b0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      we_eff[w] = i_we[w] && !i_stall && running &&
                  !((ZERO_REG != 0) && (i_waddr[w] == '0));
    end
    for (int i = 0; i < NUM_WRITE; i++) begin
      for (int j = i + 1; j < NUM_WRITE; j++) begin
        if (we_eff[i] && we_eff[j] && (i_waddr[i] == i_waddr[j])) collision = 1'b1;
      end
    end
  end

  // Port-0 banks are borrowed by the sweep until the FSM reaches RUN.
  always_comb begin
    wr_en   = we_eff;
    wr_addr = i_waddr;
    wr_data = i_wdata;
    if (!running) begin
      wr_en[0]   = 1'b1;
      wr_addr[0] = clr_cnt;
      wr_data[0] = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      o_wr_collision <= 1'b0;
    end else begin
      o_wr_collision <= collision;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) state <= RUN;
        end
        RUN:     ;
        default: state <= CLEAR;
      endcase
    end
  end

  for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wport
    for (genvar r = 0; r < NUM_READ; r++) begin : g_rport
      sdp_dist_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
      ) u_bank (
        .i_clk   (i_clk),
        .i_we    (wr_en[w]),
        .i_waddr (wr_addr[w]),
        .i_wdata (wr_data[w]),
        .i_raddr (i_raddr[r]),
        .o_rdata (bank_rdata[w][r])
      );
    end
  end

  if (NUM_WRITE > 1) begin : g_lvt
    logic [LW-1:0] lvt [DEPTH];

    // Ascending port order means the highest enabled port owns a contended address.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int a = 0; a < DEPTH; a++) lvt[a] <= '0;
      end else begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (we_eff[w]) lvt[i_waddr[w]] <= LW'(w);
        end
      end
    end

    always_comb begin
      for (int r = 0; r < NUM_READ; r++) rd_sel[r] = lvt[i_raddr[r]];
    end
  end else begin : g_no_lvt
    always_comb begin
      for (int r = 0; r < NUM_READ; r++) rd_sel[r] = '0;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      o_rdata[r] = bank_rdata[rd_sel[r]][r];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (we_eff[w] && (i_waddr[w] == i_raddr[r])) o_rdata[r] = i_wdata[w];
        end
      end
      if (!running || ((ZERO_REG != 0) && (i_raddr[r] == '0))) o_rdata[r] = '0;
    end
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Directed bench for fp_regfile_mp: default, no-bypass and zero-register instances share stimulus.
module tb_fp_regfile_mp;

  logic            clk;
  logic            rst;
  logic            stall;
  logic [1:0]      we;
  logic [1:0][4:0] waddr;
  logic [1:0][31:0] wdata;
  logic [2:0][4:0] raddr;

  logic [2:0][31:0] rd_a, rd_nb, rd_z;
  logic done_a, done_nb, done_z;
  logic coll_a, coll_nb, coll_z;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [1:0]  we;
    logic        stall;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic        ecoll;
    logic        chk_z;
  } vec_t;

  vec_t vecs [16];

  fp_regfile_mp #(.DEPTH(32), .DATA_WIDTH(32), .NUM_READ(3), .NUM_WRITE(2),
                  .ZERO_REG(0), .BYPASS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_raddr(raddr), .o_rdata(rd_a), .o_init_done(done_a),
    .o_wr_collision(coll_a));

  fp_regfile_mp #(.DEPTH(32), .DATA_WIDTH(32), .NUM_READ(3), .NUM_WRITE(2),
                  .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_raddr(raddr), .o_rdata(rd_nb), .o_init_done(done_nb),
    .o_wr_collision(coll_nb));

  fp_regfile_mp #(.DEPTH(32), .DATA_WIDTH(32), .NUM_READ(3), .NUM_WRITE(2),
                  .ZERO_REG(1), .BYPASS(1)) dut_z (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_raddr(raddr), .o_rdata(rd_z), .o_init_done(done_z),
    .o_wr_collision(coll_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  // Called right after reset is released on a falling edge; user writes are presented throughout.
  task automatic run_sweep();
    for (int k = 0; k < 32; k++) begin
      stall    = 1'b0;
      we       = 2'b11;
      waddr[0] = 5'(k);
      waddr[1] = 5'(k + 7);
      wdata[0] = 32'hFFFF_FFFF;
      wdata[1] = 32'h5A5A_5A5A;
      raddr[0] = 5'(k);
      raddr[1] = 5'(k + 1);
      raddr[2] = 5'(k + 2);
      #1;
      check("sweep_init_done_low", {31'd0, done_a}, 32'd0);
      check("sweep_rdata_forced_zero", rd_a[0] | rd_a[1] | rd_a[2], 32'd0);
      @(negedge clk);
    end
    we = 2'b00;
    #1;
    check("sweep_init_done_rise", {31'd0, done_a}, 32'd1);
    check("sweep_init_done_rise_z", {31'd0, done_z}, 32'd1);
  endtask

  task automatic read_all_zero();
    we = 2'b00;
    stall = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a);
      raddr[1] = 5'(a);
      raddr[2] = 5'(a);
      #1;
      for (int p = 0; p < 3; p++) check($sformatf("zero_f%0d_p%0d", a, p), rd_a[p], 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{2'b01, 1'b0, 5'd5,  32'h3F80_0000, 5'd0,  32'h0,         5'd5, 5'd5,  5'd5,
                 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5, 5'd5,  5'd5,
                 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 5'd0,  32'h0,         5'd5,  32'h4000_0000, 5'd5, 5'd0,  5'd1,
                 32'h4000_0000, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[3]  = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5, 5'd5,  5'd5,
                 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b0, 5'd7,  32'h1111_1111, 5'd7,  32'h2222_2222, 5'd7, 5'd7,  5'd7,
                 32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7, 5'd5,  5'd3,
                 32'h2222_2222, 32'h4000_0000, 32'h0,         1'b1, 1'b0};
    vecs[6]  = '{2'b01, 1'b0, 5'd9,  32'hDEAD_BEEF, 5'd0,  32'h0,         5'd0, 5'd0,  5'd9,
                 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 1'b1, 5'd3,  32'hAAAA_5555, 5'd0,  32'h0,         5'd3, 5'd9,  5'd3,
                 32'h0,         32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3, 5'd3,  5'd3,
                 32'h0,         32'h0,         32'h0,         1'b0, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 5'd0,  32'h1234_5678, 5'd1,  32'hCAFE_F00D, 5'd0, 5'd1,  5'd2,
                 32'h1234_5678, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0, 5'd1,  5'd9,
                 32'h1234_5678, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 1'b0, 5'd12, 32'h0000_0001, 5'd13, 32'h0000_0002, 5'd12, 5'd13, 5'd7,
                 32'h0000_0001, 32'h0000_0002, 32'h2222_2222, 1'b0, 1'b0};
    vecs[12] = '{2'b01, 1'b0, 5'd5,  32'h5555_5555, 5'd0,  32'h0,         5'd5, 5'd13, 5'd12,
                 32'h5555_5555, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5, 5'd5,  5'd3,
                 32'h5555_5555, 32'h5555_5555, 32'h0,         1'b0, 1'b0};
    vecs[14] = '{2'b11, 1'b1, 5'd7,  32'h3333_3333, 5'd7,  32'h4444_4444, 5'd7, 5'd7,  5'd7,
                 32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0};
    vecs[15] = '{2'b00, 1'b0, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7, 5'd7,  5'd7,
                 32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0};

    rst = 1'b1; stall = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
    #3;
    check("reset_init_done", {31'd0, done_a}, 32'd0);
    check("reset_collision", {31'd0, coll_a}, 32'd0);
    check("reset_rdata", rd_a[0] | rd_a[1] | rd_a[2], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_sweep();
    read_all_zero();

    for (int i = 0; i < 16; i++) begin
      stall    = vecs[i].stall;
      we       = vecs[i].we;
      waddr[0] = vecs[i].wa0;
      wdata[0] = vecs[i].wd0;
      waddr[1] = vecs[i].wa1;
      wdata[1] = vecs[i].wd1;
      raddr[0] = vecs[i].ra0;
      raddr[1] = vecs[i].ra1;
      raddr[2] = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rd0", i), rd_a[0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), rd_a[1], vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd_a[2], vecs[i].e2);
      check($sformatf("vec%0d_collision", i), {31'd0, coll_a}, {31'd0, vecs[i].ecoll});
      if (vecs[i].chk_z) check($sformatf("vec%0d_zero_reg", i), rd_z[0], 32'd0);
      @(negedge clk);
    end

    // Bypass on vs off against an existing value in f9.
    stall = 1'b0; we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h0BAD_F00D;
    raddr[0] = 5'd9; raddr[1] = 5'd9; raddr[2] = 5'd9;
    #1;
    check("bypass_on_same_cycle", rd_a[2], 32'h0BAD_F00D);
    check("bypass_off_old_value", rd_nb[2], 32'hDEAD_BEEF);
    @(negedge clk);
    we = 2'b00;
    #1;
    check("bypass_off_next_cycle", rd_nb[2], 32'h0BAD_F00D);
    @(negedge clk);

    // Fill every register, end on a collision, then reset in the middle of a cycle.
    for (int i = 0; i < 32; i++) begin
      we       = (i == 31) ? 2'b11 : 2'b01;
      waddr[0] = 5'(i);
      wdata[0] = 32'hA5A5_0000 | 32'(i + 1);
      waddr[1] = 5'd31;
      wdata[1] = 32'h7777_7777;
      @(negedge clk);
    end
    we = 2'b00; raddr[0] = 5'd31; raddr[1] = 5'd0; raddr[2] = 5'd16;
    #1;
    check("fill_collision", {31'd0, coll_a}, 32'd1);
    check("fill_f31", rd_a[0], 32'h7777_7777);
    check("fill_f0", rd_a[1], 32'hA5A5_0001);
    check("fill_f16", rd_a[2], 32'hA5A5_0011);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_init_done", {31'd0, done_a}, 32'd0);
    check("midrst_collision", {31'd0, coll_a}, 32'd0);
    check("midrst_rdata", rd_a[0] | rd_a[1] | rd_a[2], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep();
    read_all_zero();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
